reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning ROB entries (power of 2, >= 4).
REQ-002 The module SHALL have parameter FU_CNT, default 3, meaning completion ports (one per functional unit).
REQ-003 The module SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-004 The module SHALL have the dispatch ports:
- disp_valid  in  2  per-slot dispatch request, slot0 older
- disp_rd0/1  in  5  architectural destination
- disp_p_rd0/1  in  6  new physical destination
- disp_p_old_rd0/1  in  6  previous mapping of rd
- disp_ready  out  1  at least 2 free entries
- disp_rob_idx0/1  out  log2(DEPTH)  entry allocated to each slot
REQ-005 The module SHALL have the completion ports: cmpl_valid in FU_CNT, per-FU done strobe; cmpl_rob_idx in FU_CNT*log2(DEPTH), packed, FU i at bits [i*W +: W].
REQ-006 The module SHALL have the commit ports:
- commit_valid  out  2  slot0 oldest
- commit_rd0/1  out  5
- commit_p_rd0/1  out  6
- free_valid  out  2
- free_preg0/1  out  6  physical register returned to the free pool
- rob_count  out  log2(DEPTH)+1  occupied entries

Function
REQ-007 Each entry SHALL hold valid, done, rd, p_rd and p_old_rd; head and tail pointers SHALL wrap modulo DEPTH.
REQ-008 disp_ready SHALL be 1 iff rob_count <= DEPTH-2, computed from registered count with no same-cycle commit bypass.
REQ-009 When disp_ready=1, each set disp_valid bit SHALL allocate one entry at the clock edge, in slot order.
REQ-010 Allocation SHALL use disp_rob_idx0=tail and disp_rob_idx1=tail+disp_valid[0], both combinational.
REQ-011 When disp_ready=0, disp_valid SHALL be ignored and no state SHALL change from dispatch.
REQ-012 A completion strobe SHALL set done at the clock edge for a valid entry; strobes to invalid entries SHALL be ignored; duplicate strobes in the same cycle SHALL be harmless.
REQ-013 commit_valid[0] SHALL be 1 iff the head entry is valid and done; commit_valid[1] SHALL be 1 iff commit_valid[0]=1 and head+1 is valid and done.
REQ-014 Commit outputs SHALL be combinational from registered state, so an entry completed at edge k commits in the cycle after edge k.
REQ-015 Committed entries SHALL be invalidated, and head SHALL advance by the number committed, at the next edge.
REQ-016 For each committed slot, free_valid SHALL be 1 iff its rd != 0, with free_preg equal to its p_old_rd; x0 SHALL never return a register.
REQ-017 Simultaneous dispatch and commit SHALL update rob_count by +ndisp-ncommit in the same edge.
REQ-018 Commit SHALL be strictly in program order; a not-done head SHALL block all younger entries regardless of their done state.

Reset
REQ-019 On reset, head, tail and rob_count SHALL be 0 and all valid/done bits cleared.
REQ-020 During reset, commit_valid, free_valid and all data outputs SHALL be 0 and disp_ready SHALL be 1.
REQ-021 Reset asserted mid-operation SHALL discard all entries without asserting free_valid for them.

Configuration
REQ-022 With ROB_STATS_EN defined, the module SHALL add output retired_cnt (32), incremented by ncommit each edge, cleared on reset, wrapping at 2^32.
REQ-023 With ROB_STATS_EN undefined, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-024 Package rob_pkg SHALL hold AREG_W=5, PREG_W=6 and typedef rob_entry_t {valid, done, rd, p_rd, p_old_rd}.
REQ-025 The 2-wide in-order commit pick SHALL be sub-module rob_commit_select: head entries in, commit_valid and free_valid out.

Verification
REQ-026 After reset, dispatch 2 entries with rd=3/5, p_rd=33/34, p_old_rd=3/5 -> disp_rob_idx0/1=0/1 and rob_count=2.
REQ-027 Complete idx1 then idx0 on later cycles -> no commit until idx0 is done, then commit_valid=2'b11 in one cycle with free_preg0/1=3/5.
REQ-028 Fill to 14 entries -> disp_ready=1; fill to 15 -> disp_ready=0 and dispatch is ignored with tail unchanged.
REQ-029 Cycle 40 entries through the ROB -> pointers wrap 15->0, and disp_rob_idx and commit order remain correct across the wrap.
REQ-030 Commit an entry with rd=0 -> commit_valid=1 and free_valid=0.
REQ-031 Assert reset with 6 entries held -> rob_count=0 next cycle, no free_valid, and retired_cnt=0 when ROB_STATS_EN is defined.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer: register-tag widths and the ROB entry layout.
package rob_pkg;

    localparam int unsigned AREG_W = 5;
    localparam int unsigned PREG_W = 6;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [AREG_W-1:0] rd;
        logic [PREG_W-1:0] p_rd;
        logic [PREG_W-1:0] p_old_rd;
    } rob_entry_t;

    // Number of set bits in a 2-slot strobe.
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / commit bundle of the reorder buffer.
// master drives dispatch and completion, slave is the ROB.
interface reorder_buffer_if
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned FU_CNT = 3
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [1:0]              disp_valid;
    logic [AREG_W-1:0]       disp_rd0;
    logic [AREG_W-1:0]       disp_rd1;
    logic [PREG_W-1:0]       disp_p_rd0;
    logic [PREG_W-1:0]       disp_p_rd1;
    logic [PREG_W-1:0]       disp_p_old_rd0;
    logic [PREG_W-1:0]       disp_p_old_rd1;
    logic                    disp_ready;
    logic [IDX_W-1:0]        disp_rob_idx0;
    logic [IDX_W-1:0]        disp_rob_idx1;

    logic [FU_CNT-1:0]       cmpl_valid;
    logic [FU_CNT*IDX_W-1:0] cmpl_rob_idx;

    logic [1:0]              commit_valid;
    logic [AREG_W-1:0]       commit_rd0;
    logic [AREG_W-1:0]       commit_rd1;
    logic [PREG_W-1:0]       commit_p_rd0;
    logic [PREG_W-1:0]       commit_p_rd1;
    logic [1:0]              free_valid;
    logic [PREG_W-1:0]       free_preg0;
    logic [PREG_W-1:0]       free_preg1;
    logic [CNT_W-1:0]        rob_count;

    modport master (
        output disp_valid, disp_rd0, disp_rd1, disp_p_rd0, disp_p_rd1,
               disp_p_old_rd0, disp_p_old_rd1, cmpl_valid, cmpl_rob_idx,
        input  disp_ready, disp_rob_idx0, disp_rob_idx1, commit_valid,
               commit_rd0, commit_rd1, commit_p_rd0, commit_p_rd1,
               free_valid, free_preg0, free_preg1, rob_count
    );

    modport slave (
        input  disp_valid, disp_rd0, disp_rd1, disp_p_rd0, disp_p_rd1,
               disp_p_old_rd0, disp_p_old_rd1, cmpl_valid, cmpl_rob_idx,
        output disp_ready, disp_rob_idx0, disp_rob_idx1, commit_valid,
               commit_rd0, commit_rd1, commit_p_rd0, commit_p_rd1,
               free_valid, free_preg0, free_preg1, rob_count
    );

endinterface

// File: rtl/rob_commit_select.sv
// Two-wide in-order commit pick from the two oldest ROB entries.
module rob_commit_select
    import rob_pkg::*;
(
    input  logic       en_i,
    input  rob_entry_t head0_i,
    input  rob_entry_t head1_i,
    output logic [1:0] commit_valid_o,
    output logic [1:0] free_valid_o
);

    logic c0;
    logic c1;

    // Slot 1 may only retire behind slot 0; x0 never owns a physical register.
    always_comb begin
        c0             = 1'b0;
        c1             = 1'b0;
        commit_valid_o = 2'b00;
        free_valid_o   = 2'b00;
        c0             = en_i & head0_i.valid & head0_i.done;
        c1             = c0 & head1_i.valid & head1_i.done;
        commit_valid_o = {c1, c0};
        free_valid_o   = {c1 & (head1_i.rd != '0), c0 & (head0_i.rd != '0)};
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: 2-wide dispatch, FU_CNT completion ports, 2-wide in-order commit.
// Optional ROB_STATS_EN adds a 32-bit retired-instruction counter (retired_cnt).
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned FU_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    reorder_buffer_if.slave  rob
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]      retired_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    rob_entry_t       entries_q [DEPTH];
    rob_entry_t       entries_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ready_c;
    logic [1:0]       fire_c;
    logic [IDX_W-1:0] idx0_c, idx1_c, head1_c, cidx_c;
    logic [1:0]       commit_c, free_c;
    logic [1:0]       ndisp_c, ncommit_c;
    rob_entry_t       head0_e, head1_e;

    // Readiness uses the registered count only; a same-cycle commit does not help.
    assign ready_c = (count_q <= CNT_W'(DEPTH - 2));
    assign fire_c  = ready_c ? rob.disp_valid : 2'b00;
    assign idx0_c  = tail_q;
    assign idx1_c  = tail_q + IDX_W'(rob.disp_valid[0]);
    assign head1_c = head_q + IDX_W'(1);
    assign head0_e = entries_q[head_q];
    assign head1_e = entries_q[head1_c];

    rob_commit_select u_commit_select (
        .en_i          (~reset),
        .head0_i       (head0_e),
        .head1_i       (head1_e),
        .commit_valid_o(commit_c),
        .free_valid_o  (free_c)
    );

    assign ndisp_c   = pop2(fire_c);
    assign ncommit_c = pop2(commit_c);

    // Next state: completions, then commit invalidation, then allocation.
    always_comb begin
        entries_d = entries_q;
        cidx_c    = '0;
        for (int i = 0; i < int'(FU_CNT); i++) begin
            cidx_c = rob.cmpl_rob_idx[i*IDX_W +: IDX_W];
            if (rob.cmpl_valid[i] && entries_q[cidx_c].valid) begin
                entries_d[cidx_c].done = 1'b1;
            end
        end
        if (commit_c[0]) begin
            entries_d[head_q] = '0;
        end
        if (commit_c[1]) begin
            entries_d[head1_c] = '0;
        end
        if (fire_c[0]) begin
            entries_d[idx0_c] = '{valid: 1'b1, done: 1'b0, rd: rob.disp_rd0,
                                  p_rd: rob.disp_p_rd0, p_old_rd: rob.disp_p_old_rd0};
        end
        if (fire_c[1]) begin
            entries_d[idx1_c] = '{valid: 1'b1, done: 1'b0, rd: rob.disp_rd1,
                                  p_rd: rob.disp_p_rd1, p_old_rd: rob.disp_p_old_rd1};
        end
        head_d  = head_q + IDX_W'(ncommit_c);
        tail_d  = tail_q + IDX_W'(ndisp_c);
        count_d = count_q + CNT_W'(ndisp_c) - CNT_W'(ncommit_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // Outputs are forced quiet while reset is held so nothing leaks from stale state.
    assign rob.disp_ready    = reset | ready_c;
    assign rob.disp_rob_idx0 = reset ? '0 : idx0_c;
    assign rob.disp_rob_idx1 = reset ? '0 : idx1_c;
    assign rob.rob_count     = reset ? '0 : count_q;

    assign rob.commit_valid  = commit_c;
    assign rob.commit_rd0    = commit_c[0] ? head0_e.rd   : '0;
    assign rob.commit_rd1    = commit_c[1] ? head1_e.rd   : '0;
    assign rob.commit_p_rd0  = commit_c[0] ? head0_e.p_rd : '0;
    assign rob.commit_p_rd1  = commit_c[1] ? head1_e.p_rd : '0;
    assign rob.free_valid    = free_c;
    assign rob.free_preg0    = free_c[0] ? head0_e.p_old_rd : '0;
    assign rob.free_preg1    = free_c[1] ? head1_e.p_old_rd : '0;

`ifdef ROB_STATS_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + 32'(ncommit_c);
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus reset, fill and wrap sequences.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned FU_CNT = 3;
    localparam int          NV     = 17;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    reorder_buffer_if #(.DEPTH(DEPTH), .FU_CNT(FU_CNT)) rob_if ();

`ifdef ROB_STATS_EN
    logic [31:0] retired_cnt;
`endif

    reorder_buffer #(.DEPTH(DEPTH), .FU_CNT(FU_CNT)) dut (
        .clk  (clk),
        .reset(reset),
        .rob  (rob_if)
`ifdef ROB_STATS_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] dv;
        logic [4:0] r0, r1;
        logic [5:0] p0, p1, o0, o1;
        logic [2:0] cm;
        logic [3:0] c0, c1, c2;
        logic       e_rdy;
        logic [3:0] e_i0, e_i1;
        logic [1:0] e_cv, e_fv;
        logic [5:0] e_fp0, e_fp1;
        logic [4:0] e_crd0;
        logic [5:0] e_cprd0;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input int dv, r0, r1, p0, p1, o0, o1, cm, c0, c1, c2,
                                input int rdy, i0, i1, cv, fv, fp0, fp1, crd0, cprd0, cnt);
        vec_t v;
        v.dv = 2'(dv); v.r0 = 5'(r0); v.r1 = 5'(r1);
        v.p0 = 6'(p0); v.p1 = 6'(p1); v.o0 = 6'(o0); v.o1 = 6'(o1);
        v.cm = 3'(cm); v.c0 = 4'(c0); v.c1 = 4'(c1); v.c2 = 4'(c2);
        v.e_rdy = 1'(rdy); v.e_i0 = 4'(i0); v.e_i1 = 4'(i1);
        v.e_cv = 2'(cv); v.e_fv = 2'(fv); v.e_fp0 = 6'(fp0); v.e_fp1 = 6'(fp1);
        v.e_crd0 = 5'(crd0); v.e_cprd0 = 6'(cprd0); v.e_cnt = 5'(cnt);
        return v;
    endfunction

    task automatic set_in(input logic [1:0] dv, input logic [4:0] r0, r1,
                          input logic [5:0] p0, p1, o0, o1,
                          input logic [2:0] cm, input logic [3:0] c0, c1, c2);
        rob_if.disp_valid     = dv;
        rob_if.disp_rd0       = r0;
        rob_if.disp_rd1       = r1;
        rob_if.disp_p_rd0     = p0;
        rob_if.disp_p_rd1     = p1;
        rob_if.disp_p_old_rd0 = o0;
        rob_if.disp_p_old_rd1 = o1;
        rob_if.cmpl_valid     = cm;
        rob_if.cmpl_rob_idx   = {c2, c1, c0};
    endtask

    // Behavioural ROB model for the multi-cycle sequences.
    logic       m_v   [16];
    logic       m_d   [16];
    logic [4:0] m_rd  [16];
    logic [5:0] m_prd [16];
    logic [5:0] m_old [16];
    int         m_head, m_tail, m_count;

    task automatic m_reset(input int base);
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0; m_d[i] = 1'b0; m_rd[i] = '0; m_prd[i] = '0; m_old[i] = '0;
        end
        m_head = base; m_tail = base; m_count = 0;
    endtask

    task automatic step(input logic [1:0] dv, input logic [4:0] r0, r1,
                        input logic [5:0] p0, p1, o0, o1,
                        input logic [2:0] cm, input logic [3:0] c0, c1, c2);
        int         h1, nc, nd, t1;
        logic       e0, e1, rdy;
        logic [3:0] ci [3];
        @(negedge clk);
        set_in(dv, r0, r1, p0, p1, o0, o1, cm, c0, c1, c2);
        #1;
        h1  = (m_head + 1) % 16;
        t1  = (m_tail + int'(dv[0])) % 16;
        e0  = m_v[m_head] && m_d[m_head];
        e1  = e0 && m_v[h1] && m_d[h1];
        rdy = (m_count <= 14);
        chk("s.disp_ready", 32'(rob_if.disp_ready), 32'(rdy));
        chk("s.idx0", 32'(rob_if.disp_rob_idx0), 32'(m_tail));
        chk("s.idx1", 32'(rob_if.disp_rob_idx1), 32'(t1));
        chk("s.commit_valid", 32'(rob_if.commit_valid), 32'({e1, e0}));
        chk("s.free_valid", 32'(rob_if.free_valid),
            32'({e1 && (m_rd[h1] != 0), e0 && (m_rd[m_head] != 0)}));
        chk("s.rob_count", 32'(rob_if.rob_count), 32'(m_count));
        if (e0) begin
            chk("s.commit_rd0", 32'(rob_if.commit_rd0), 32'(m_rd[m_head]));
            chk("s.commit_p_rd0", 32'(rob_if.commit_p_rd0), 32'(m_prd[m_head]));
            if (m_rd[m_head] != 0) chk("s.free_preg0", 32'(rob_if.free_preg0), 32'(m_old[m_head]));
        end
        if (e1) begin
            chk("s.commit_p_rd1", 32'(rob_if.commit_p_rd1), 32'(m_prd[h1]));
            if (m_rd[h1] != 0) chk("s.free_preg1", 32'(rob_if.free_preg1), 32'(m_old[h1]));
        end
        ci[0] = c0; ci[1] = c1; ci[2] = c2;
        for (int i = 0; i < 3; i++) begin
            if (cm[i] && m_v[ci[i]]) m_d[ci[i]] = 1'b1;
        end
        nc = int'(e0) + int'(e1);
        if (e0) begin m_v[m_head] = 1'b0; m_d[m_head] = 1'b0; end
        if (e1) begin m_v[h1] = 1'b0; m_d[h1] = 1'b0; end
        m_head = (m_head + nc) % 16;
        nd = 0;
        if (rdy) begin
            if (dv[0]) begin
                m_v[m_tail] = 1'b1; m_d[m_tail] = 1'b0;
                m_rd[m_tail] = r0; m_prd[m_tail] = p0; m_old[m_tail] = o0;
            end
            if (dv[1]) begin
                m_v[t1] = 1'b1; m_d[t1] = 1'b0;
                m_rd[t1] = r1; m_prd[t1] = p1; m_old[t1] = o1;
            end
            nd = int'(dv[0]) + int'(dv[1]);
        end
        m_tail  = (m_tail + nd) % 16;
        m_count = m_count + nd - nc;
    endtask

    task automatic idle();
        step(2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'b000, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            dv r0 r1 p0 p1 o0 o1 cm c0 c1 c2 rdy i0 i1 cv fv fp0 fp1 crd cprd cnt
        vecs[0]  = mk(3, 3, 5, 33, 34, 3, 5,  0, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0,  0, 0);
        vecs[1]  = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 2, 2, 0, 0,  0, 0, 0,  0, 2);
        vecs[2]  = mk(0, 0, 0,  0,  0, 0, 0,  1, 1, 0, 0, 1, 2, 2, 0, 0,  0, 0, 0,  0, 2);
        vecs[3]  = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 2, 2, 0, 0,  0, 0, 0,  0, 2);
        vecs[4]  = mk(0, 0, 0,  0,  0, 0, 0,  2, 0, 0, 0, 1, 2, 2, 0, 0,  0, 0, 0,  0, 2);
        vecs[5]  = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 2, 2, 3, 3,  3, 5, 3, 33, 2);
        vecs[6]  = mk(1, 0, 0, 40,  0, 7, 0,  0, 0, 0, 0, 1, 2, 3, 0, 0,  0, 0, 0,  0, 0);
        vecs[7]  = mk(2, 0, 9,  0, 41, 0, 12, 4, 0, 0, 2, 1, 3, 3, 0, 0,  0, 0, 0,  0, 1);
        vecs[8]  = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 4, 4, 1, 0,  0, 0, 0, 40, 2);
        vecs[9]  = mk(0, 0, 0,  0,  0, 0, 0,  7, 3, 3, 5, 1, 4, 4, 0, 0,  0, 0, 0,  0, 1);
        vecs[10] = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 4, 4, 1, 1, 12, 0, 9, 41, 1);
        vecs[11] = mk(3, 1, 2, 10, 11, 20, 21, 0, 0, 0, 0, 1, 4, 5, 0, 0,  0, 0, 0,  0, 0);
        vecs[12] = mk(0, 0, 0,  0,  0, 0, 0,  1, 4, 0, 0, 1, 6, 6, 0, 0,  0, 0, 0,  0, 2);
        vecs[13] = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 6, 6, 1, 1, 20, 0, 1, 10, 2);
        vecs[14] = mk(0, 0, 0,  0,  0, 0, 0,  2, 0, 5, 0, 1, 6, 6, 0, 0,  0, 0, 0,  0, 1);
        vecs[15] = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 6, 6, 1, 1, 21, 0, 2, 11, 1);
        vecs[16] = mk(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 6, 6, 0, 0,  0, 0, 0,  0, 0);

        set_in(2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("rst.commit_valid", 32'(rob_if.commit_valid), 32'd0);
        chk("rst.free_valid", 32'(rob_if.free_valid), 32'd0);
        chk("rst.disp_ready", 32'(rob_if.disp_ready), 32'd1);
        chk("rst.rob_count", 32'(rob_if.rob_count), 32'd0);
        chk("rst.free_preg0", 32'(rob_if.free_preg0), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            set_in(vecs[k].dv, vecs[k].r0, vecs[k].r1, vecs[k].p0, vecs[k].p1,
                   vecs[k].o0, vecs[k].o1, vecs[k].cm, vecs[k].c0, vecs[k].c1, vecs[k].c2);
            #1;
            chk($sformatf("v%0d.disp_ready", k), 32'(rob_if.disp_ready), 32'(vecs[k].e_rdy));
            chk($sformatf("v%0d.idx0", k), 32'(rob_if.disp_rob_idx0), 32'(vecs[k].e_i0));
            chk($sformatf("v%0d.idx1", k), 32'(rob_if.disp_rob_idx1), 32'(vecs[k].e_i1));
            chk($sformatf("v%0d.commit_valid", k), 32'(rob_if.commit_valid), 32'(vecs[k].e_cv));
            chk($sformatf("v%0d.free_valid", k), 32'(rob_if.free_valid), 32'(vecs[k].e_fv));
            chk($sformatf("v%0d.rob_count", k), 32'(rob_if.rob_count), 32'(vecs[k].e_cnt));
            if (vecs[k].e_cv[0]) begin
                chk($sformatf("v%0d.commit_rd0", k), 32'(rob_if.commit_rd0), 32'(vecs[k].e_crd0));
                chk($sformatf("v%0d.commit_p_rd0", k), 32'(rob_if.commit_p_rd0), 32'(vecs[k].e_cprd0));
            end
            if (vecs[k].e_fv[0]) chk($sformatf("v%0d.free_preg0", k), 32'(rob_if.free_preg0), 32'(vecs[k].e_fp0));
            if (vecs[k].e_fv[1]) chk($sformatf("v%0d.free_preg1", k), 32'(rob_if.free_preg1), 32'(vecs[k].e_fp1));
        end
`ifdef ROB_STATS_EN
        chk("stats.retired6", retired_cnt, 32'd6);
`endif

        // Reset with six entries held, the head one already done.
        m_reset(6);
        step(2'b11, 5'd1, 5'd2, 6'd50, 6'd51, 6'd60, 6'd61, 3'b000, 4'd0, 4'd0, 4'd0);
        step(2'b11, 5'd3, 5'd4, 6'd52, 6'd53, 6'd62, 6'd63, 3'b000, 4'd0, 4'd0, 4'd0);
        step(2'b11, 5'd5, 5'd6, 6'd54, 6'd55, 6'd40, 6'd41, 3'b001, 4'd6, 4'd0, 4'd0);
        @(negedge clk);
        set_in(2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;
        #1;
        chk("midrst.commit_valid", 32'(rob_if.commit_valid), 32'd0);
        chk("midrst.free_valid", 32'(rob_if.free_valid), 32'd0);
        chk("midrst.disp_ready", 32'(rob_if.disp_ready), 32'd1);
        chk("midrst.rob_count", 32'(rob_if.rob_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst.rob_count", 32'(rob_if.rob_count), 32'd0);
        chk("postrst.commit_valid", 32'(rob_if.commit_valid), 32'd0);
        chk("postrst.free_valid", 32'(rob_if.free_valid), 32'd0);
        chk("postrst.idx0", 32'(rob_if.disp_rob_idx0), 32'd0);
`ifdef ROB_STATS_EN
        chk("postrst.retired_cnt", retired_cnt, 32'd0);
`endif
        m_reset(0);

        // Fill to 14 and 15, then a rejected dispatch, then drain.
        for (int k = 0; k < 7; k++) begin
            step(2'b11, 5'(k % 8), 5'((k + 3) % 8), 6'(32 + 2 * k), 6'(33 + 2 * k),
                 6'(2 * k), 6'(2 * k + 1), 3'b000, 4'd0, 4'd0, 4'd0);
        end
        step(2'b01, 5'd7, 5'd0, 6'd46, 6'd0, 6'd20, 6'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        step(2'b11, 5'd1, 5'd2, 6'd47, 6'd48, 6'd21, 6'd22, 3'b000, 4'd0, 4'd0, 4'd0);
        idle();
        for (int k = 0; k < 5; k++) begin
            step(2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'b111,
                 4'(3 * k), 4'(3 * k + 1), 4'(3 * k + 2));
        end
        for (int g = 0; g < 20 && m_count > 0; g++) idle();

        // Stream 40 entries across the pointer wrap, sometimes holding back the head.
        begin
            int         sent, cyc, nsel, idx, seq;
            logic [1:0] dv;
            logic [2:0] cm;
            logic [3:0] cs [3];
            sent = 0; cyc = 0; seq = 0;
            while ((sent < 40 || m_count > 0) && cyc < 300) begin
                dv = (sent >= 40) ? 2'b00 : ((sent == 39) ? 2'b01 : 2'b11);
                cm = 3'b000; nsel = 0;
                cs[0] = '0; cs[1] = '0; cs[2] = '0;
                for (int j = 0; j < m_count && nsel < 3; j++) begin
                    idx = (m_head + j) % 16;
                    if (m_v[idx] && !m_d[idx] && !(j == 0 && (cyc % 3) == 0)) begin
                        cs[nsel] = 4'(idx);
                        cm[nsel] = 1'b1;
                        nsel++;
                    end
                end
                if (m_count <= 14) sent += int'(dv[0]) + int'(dv[1]);
                step(dv, 5'(seq % 8), 5'((seq + 1) % 8), 6'(32 + seq % 32), 6'(32 + (seq + 1) % 32),
                     6'(seq % 64), 6'((seq + 1) % 64), cm, cs[0], cs[1], cs[2]);
                seq += 2;
                cyc++;
            end
            chk("wrap.all_sent", 32'(sent), 32'd40);
            idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
